// File: rtl/cic_comp_fir_if.sv
// Sample-in / result-out bundle between the CIC decimator, the compensation FIR and its consumer.
// The slave modport is the filter side; master is the driver/consumer side.
interface cic_comp_fir_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16
);
  logic signed [DATA_WIDTH-1:0] din;
  logic                         din_valid;
  logic                         clr_overrun;
  logic signed [OUT_WIDTH-1:0]  dout;
  logic                         dout_valid;
  logic                         busy;
  logic                         overrun;

  modport master (
    output din, din_valid, clr_overrun,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  din, din_valid, clr_overrun,
    output dout, dout_valid, busy, overrun
  );
endinterface

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: serial MAC (one tap per clk), output decimated by DECIM, result NTAPS+2 clk after trigger.
// No backpressure upstream: samples arriving while MAC/OUT is running are dropped and flagged in sticky overrun.
module cic_comp_fir #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int NTAPS      = 9,
  parameter int DECIM      = 2,
  parameter int OUT_WIDTH  = 16,
  parameter logic signed [COEF_WIDTH-1:0] COEFS [NTAPS] =
    '{-512, 0, 4608, 8192, 8192, 8192, 4608, 0, -512}
) (
  input  logic          clk,
  input  logic          rst_n,
  cic_comp_fir_if.slave bus
);
  localparam int K_W    = $clog2(NTAPS);
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);
  localparam int RND_W  = ACC_W + 1;

  localparam logic [K_W-1:0]  K_LAST  = K_W'(NTAPS - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) << (COEF_WIDTH - 2);
  localparam logic signed [RND_W-1:0] OUT_MAX =
    {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] OUT_MIN =
    {{(RND_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_q, state_d;
  logic   busy, mac_en, out_en;
  logic   accept, drop, trigger;

  logic signed [DATA_WIDTH-1:0] x_q [NTAPS];
  logic signed [DATA_WIDTH-1:0] x_d [NTAPS];
  logic [PH_W-1:0]              phase_q, phase_d;
  logic [K_W-1:0]               k_q, k_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]  dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;
  logic                         overrun_q, overrun_d;

  logic signed [PROD_W-1:0]     x_ext, c_ext, prod;
  logic signed [RND_W-1:0]      rnd, shifted;
  logic signed [OUT_WIDTH-1:0]  sat;

  assign accept  = bus.din_valid && !busy;
  assign drop    = bus.din_valid && busy;
  assign trigger = accept && (phase_q == PH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = MAC;
      MAC:     if (k_q == K_LAST) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    mac_en = 1'b0;
    out_en = 1'b0;
    case (state_q)
      MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
      end
      OUT: begin
        busy   = 1'b1;
        out_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Single shared multiplier: tap k of the delay line times coefficient k.
  always_comb begin
    x_ext = PROD_W'(x_q[k_q]);
    c_ext = PROD_W'(COEFS[k_q]);
    prod  = x_ext * c_ext;
  end

  always_comb begin
    rnd     = {acc_q[ACC_W-1], acc_q} + RND_HALF;
    shifted = rnd >>> (COEF_WIDTH - 1);
    if (shifted > OUT_MAX) begin
      sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (shifted < OUT_MIN) begin
      sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      sat = shifted[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    x_d = x_q;
    if (accept) begin
      x_d[0] = bus.din;
      for (int i = 1; i < NTAPS; i++) x_d[i] = x_q[i-1];
    end

    phase_d = phase_q;
    if (accept) phase_d = trigger ? '0 : phase_q + PH_W'(1);

    k_d   = k_q;
    acc_d = acc_q;
    if (trigger) begin
      k_d   = '0;
      acc_d = '0;
    end else if (mac_en) begin
      k_d   = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
      acc_d = acc_q + ACC_W'(prod);
    end

    dout_d       = out_en ? sat : dout_q;
    dout_valid_d = out_en;

    // A drop in the same cycle as a clear must leave the flag set.
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
      phase_q      <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      x_q          <= x_d;
      phase_q      <= phase_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: three instances (default, flat 16384, flat 32767 taps) share one stimulus stream;
// expected outputs are computed from a behavioural convolution model and queued with their due cycle.
module tb_cic_comp_fir;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int NT  = 9;
  localparam int DEC = 2;
  localparam int OW  = 16;
  localparam int LAT = NT + 2;
  localparam int CDEF [NT] = '{-512, 0, 4608, 8192, 8192, 8192, 4608, 0, -512};
  localparam int IMP  [5]  = '{-512, 4608, 8192, 4608, -512};
  localparam logic signed [CW-1:0] C_HALF [NT] = '{default: 16'sd16384};
  localparam logic signed [CW-1:0] C_SAT  [NT] = '{default: 16'sd32767};

  typedef struct packed {
    int     cyc;
    longint vd;
    longint vh;
    longint vs;
  } exp_t;

  logic                 clk         = 1'b0;
  logic                 rst_n       = 1'b0;
  logic signed [DW-1:0] din         = '0;
  logic                 din_valid   = 1'b0;
  logic                 clr_overrun = 1'b0;

  int     cyc       = 0;
  int     checks    = 0;
  int     errors    = 0;
  int     busy_cnt  = 0;
  int     valid_cnt = 0;
  int     n_trig    = 0;
  int     phase_m   = 0;
  int     last_trig = -1000;
  int     vc0;
  logic   exp_ovr   = 1'b0;
  longint hist [NT];
  exp_t   sb [$];
  longint cap_d [$];
  longint cap_h [$];
  longint cap_s [$];
  logic signed [OW-1:0] hold_d = '0;

  cic_comp_fir_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) if_d ();
  cic_comp_fir_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) if_h ();
  cic_comp_fir_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) if_s ();

  assign if_d.din = din;
  assign if_d.din_valid = din_valid;
  assign if_d.clr_overrun = clr_overrun;
  assign if_h.din = din;
  assign if_h.din_valid = din_valid;
  assign if_h.clr_overrun = clr_overrun;
  assign if_s.din = din;
  assign if_s.din_valid = din_valid;
  assign if_s.clr_overrun = clr_overrun;

  cic_comp_fir dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));
  cic_comp_fir #(.COEFS(C_HALF)) dut_h (.clk(clk), .rst_n(rst_n), .bus(if_h.slave));
  cic_comp_fir #(.COEFS(C_SAT))  dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_out(input int set);
    longint acc = 0;
    longint r;
    for (int k = 0; k < NT; k++)
      acc += hist[k] * longint'((set == 0) ? CDEF[k] : ((set == 1) ? 16384 : 32767));
    r = (acc + (longint'(1) <<< (CW - 2))) >>> (CW - 1);
    if (r > (longint'(1) <<< (OW - 1)) - 1) r = (longint'(1) <<< (OW - 1)) - 1;
    if (r < -(longint'(1) <<< (OW - 1))) r = -(longint'(1) <<< (OW - 1));
    return r;
  endfunction

  task automatic model_in(input logic signed [DW-1:0] v);
    if (cyc >= last_trig + 1 && cyc <= last_trig + NT + 1) begin
      exp_ovr = 1'b1;
    end else begin
      for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = longint'(v);
      if (phase_m == DEC - 1) begin
        sb.push_back('{cyc + LAT, ref_out(0), ref_out(1), ref_out(2)});
        last_trig = cyc;
        n_trig++;
        phase_m = 0;
      end else begin
        phase_m++;
      end
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NT; i++) hist[i] = 0;
    phase_m   = 0;
    last_trig = -1000;
    exp_ovr   = 1'b0;
    sb.delete();
  endtask

  task automatic drive(input logic vld, input logic signed [DW-1:0] v, input logic clr, input int gap);
    din         = v;
    din_valid   = vld;
    clr_overrun = clr;
    if (clr) exp_ovr = 1'b0;
    if (vld) model_in(v);
    @(posedge clk); #1;
    din_valid   = 1'b0;
    clr_overrun = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      hold_d = '0;
    end else begin
      if (if_d.busy) busy_cnt++;
      if (if_d.dout_valid || if_h.dout_valid || if_s.dout_valid) begin
        valid_cnt++;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          chk("valid_all", {if_d.dout_valid, if_h.dout_valid, if_s.dout_valid}, 3'b111);
          chk("dout_def", if_d.dout, e.vd);
          chk("dout_half", if_h.dout, e.vh);
          chk("dout_sat", if_s.dout, e.vs);
        end
        cap_d.push_back(longint'(if_d.dout));
        cap_h.push_back(longint'(if_h.dout));
        cap_s.push_back(longint'(if_s.dout));
        hold_d = if_d.dout;
      end else begin
        chk("dout_hold", if_d.dout, hold_d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", if_d.dout, 0);
    chk("rst_valid", if_d.dout_valid, 0);
    chk("rst_busy", if_d.busy, 0);
    chk("rst_ovr", if_d.overrun, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse on the second sample lands on even-indexed taps at each trigger.
    cap_d.delete();
    drive(1'b1, 16'sd0, 1'b0, 12);
    drive(1'b1, 16'sd32767, 1'b0, 12);
    for (int i = 0; i < 10; i++) drive(1'b1, 16'sd0, 1'b0, 12);
    chk("imp_count", cap_d.size(), 6);
    for (int i = 0; i < 5; i++) chk("imp_tap", cap_d[i], IMP[i]);

    cap_d.delete(); cap_h.delete();
    for (int i = 0; i < 14; i++) drive(1'b1, 16'sd1000, 1'b0, 12);
    chk("dc_half", cap_h[cap_h.size()-1], 4500);
    chk("dc_def", cap_d[cap_d.size()-1], 1000);

    cap_d.delete(); cap_s.delete();
    for (int i = 0; i < 12; i++) drive(1'b1, 16'sd32767, 1'b0, 12);
    chk("sat_pos", cap_s[cap_s.size()-1], 32767);
    chk("pos_def", cap_d[cap_d.size()-1], 32767);
    cap_h.delete(); cap_s.delete();
    for (int i = 0; i < 12; i++) drive(1'b1, -16'sd32768, 1'b0, 12);
    chk("sat_neg", cap_s[cap_s.size()-1], -32768);
    chk("sat_neg_half", cap_h[cap_h.size()-1], -32768);

    chk("ovr_clean", if_d.overrun, 0);
    busy_cnt = 0;
    n_trig   = 0;
    for (int i = 0; i < 12; i++) drive(1'b1, 16'(i * 300), 1'b0, 4);
    repeat (LAT) @(posedge clk);
    #1;
    chk("busy_cycles", busy_cnt, n_trig * (NT + 1));
    chk("ovr_set", if_d.overrun, 1);
    drive(1'b0, 16'sd0, 1'b1, 1);
    chk("ovr_clr", if_d.overrun, 0);

    if (phase_m != DEC - 1) drive(1'b1, 16'sd7, 1'b0, 12);
    drive(1'b1, 16'sd11, 1'b0, 2);
    drive(1'b1, 16'sd99, 1'b1, 1);
    chk("ovr_drop_wins", if_d.overrun, 1);
    repeat (12) @(posedge clk);
    #1;
    drive(1'b0, 16'sd0, 1'b1, 1);
    chk("ovr_clr2", if_d.overrun, 0);
    repeat (12) @(posedge clk);
    #1;

    // Reset lands in the third MAC cycle after a drop has set overrun.
    if (phase_m != DEC - 1) drive(1'b1, 16'sd5, 1'b0, 12);
    drive(1'b1, 16'sd1234, 1'b0, 1);
    drive(1'b1, 16'sd77, 1'b0, 1);
    chk("ovr_pre_rst", if_d.overrun, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    reset_model();
    vc0 = valid_cnt;
    #1;
    chk("mid_rst_dout", if_d.dout, 0);
    chk("mid_rst_valid", if_d.dout_valid, 0);
    chk("mid_rst_busy", if_d.busy, 0);
    chk("mid_rst_ovr", if_d.overrun, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_valid", valid_cnt - vc0, 0);

    cap_d.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'sd100, 1'b0, 12);
    chk("post_rst_count", cap_d.size(), 2);
    chk("post_rst_first", cap_d[0], -2);
    chk("post_rst_second", cap_d[1], 38);

    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
